// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: states, opcodes and datapath mux codes.
package multicycle_ctrl_pkg;

   typedef logic [3:0] state_t;

   localparam state_t S_FETCH  = 4'd0;
   localparam state_t S_DECODE = 4'd1;
   localparam state_t S_MEMADR = 4'd2;
   localparam state_t S_MEMRD  = 4'd3;
   localparam state_t S_MEMWB  = 4'd4;
   localparam state_t S_MEMWR  = 4'd5;
   localparam state_t S_EXEC_R = 4'd6;
   localparam state_t S_EXEC_I = 4'd7;
   localparam state_t S_ALUWB  = 4'd8;
   localparam state_t S_BRANCH = 4'd9;
   localparam state_t S_JAL    = 4'd10;
   localparam state_t S_LUI    = 4'd11;
   localparam state_t S_TRAP   = 4'd12;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_FN  = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2 = 2'b00;
   localparam logic [1:0] SRCB_IMM = 2'b01;
   localparam logic [1:0] SRCB_4   = 2'b10;

   localparam logic [1:0] RES_ALUREG = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle FSM (master) and the RV32I datapath/memory (slave).
interface multicycle_ctrl_if;
   import multicycle_ctrl_pkg::*;

   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       MemWrite;
   logic       AdrSrc;
   logic       IRWrite;
   logic       PCWrite;
   logic       RegWrite;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic [1:0] ResultSrc;
   logic       retire;
   logic       bus_err;
   logic       illegal;
   state_t     state;

   modport master (
      input  opcode, zero, mem_ready,
      output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
             ALUSrcA, ALUSrcB, ALUOp, ResultSrc, retire, bus_err, illegal, state
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
             ALUSrcA, ALUSrcB, ALUOp, ResultSrc, retire, bus_err, illegal, state
   );

endinterface

// File: rtl/multicycle_ctrl_timer.sv
// Memory wait counter: counts stalled cycles of an access and flags a timeout on the last allowed one.
module mem_wait_timer #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic ready,
   output logic timeout
);

   logic [CNT_W-1:0] cnt;

   // Idle cycles keep the counter at zero so every access starts fresh.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  cnt <= '0;
      else if (!active || ready) cnt <= '0;
      else                      cnt <= cnt + 1'b1;
   end

   assign timeout = active && !ready && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH..WB, drives datapath strobes, traps on timeout/illegal.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic clk,
   input  logic rst,
   multicycle_ctrl_if.master bus
);

   state_t st, nxt;
   logic   tmo, mem_state, legal, bus_err_q, illegal_q;

   assign mem_state = (st == S_FETCH) || (st == S_MEMRD) || (st == S_MEMWR);

   always_comb begin
      legal = 1'b0;
      case (bus.opcode)
         OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_LUI: legal = 1'b1;
         default:                                               legal = 1'b0;
      endcase
   end

   mem_wait_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .active  (mem_state),
      .ready   (bus.mem_ready),
      .timeout (tmo)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) st <= S_FETCH;
      else     st <= nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_err_q <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         if (tmo)                      bus_err_q <= 1'b1;
         if (st == S_DECODE && !legal) illegal_q <= 1'b1;
      end
   end

   always_comb begin
      nxt = st;
      case (st)
         S_FETCH:  if (bus.mem_ready) nxt = S_DECODE; else if (tmo) nxt = S_TRAP;
         S_DECODE: begin
            case (bus.opcode)
               OP_LOAD, OP_STORE: nxt = S_MEMADR;
               OP_R:              nxt = S_EXEC_R;
               OP_I:              nxt = S_EXEC_I;
               OP_BR:             nxt = S_BRANCH;
               OP_JAL:            nxt = S_JAL;
               OP_LUI:            nxt = S_LUI;
               default:           nxt = S_TRAP;
            endcase
         end
         S_MEMADR: nxt = (bus.opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (bus.mem_ready) nxt = S_MEMWB; else if (tmo) nxt = S_TRAP;
         S_MEMWR:  if (bus.mem_ready) nxt = S_FETCH; else if (tmo) nxt = S_TRAP;
         S_MEMWB, S_ALUWB, S_BRANCH:          nxt = S_FETCH;
         S_EXEC_R, S_EXEC_I, S_JAL, S_LUI:    nxt = S_ALUWB;
         default:  nxt = S_TRAP;
      endcase
   end

   // Moore decode; only IRWrite/PCWrite/retire look at mem_ready or zero.
   always_comb begin
      bus.mem_req   = 1'b0;
      bus.MemWrite  = 1'b0;
      bus.AdrSrc    = 1'b0;
      bus.IRWrite   = 1'b0;
      bus.PCWrite   = 1'b0;
      bus.RegWrite  = 1'b0;
      bus.ALUSrcA   = SRCA_PC;
      bus.ALUSrcB   = SRCB_RS2;
      bus.ALUOp     = ALU_ADD;
      bus.ResultSrc = RES_ALUREG;
      bus.retire    = 1'b0;
      case (st)
         S_FETCH: begin
            bus.mem_req   = 1'b1;
            bus.ALUSrcB   = SRCB_4;
            bus.ResultSrc = RES_ALU;
            bus.IRWrite   = bus.mem_ready;
            bus.PCWrite   = bus.mem_ready;
         end
         S_DECODE: begin
            bus.ALUSrcA = SRCA_OLDPC;
            bus.ALUSrcB = SRCB_IMM;
         end
         S_MEMADR: begin
            bus.ALUSrcA = SRCA_RS1;
            bus.ALUSrcB = SRCB_IMM;
         end
         S_MEMRD: begin
            bus.mem_req = 1'b1;
            bus.AdrSrc  = 1'b1;
         end
         S_MEMWB: begin
            bus.ResultSrc = RES_MEM;
            bus.RegWrite  = 1'b1;
            bus.retire    = 1'b1;
         end
         S_MEMWR: begin
            bus.mem_req  = 1'b1;
            bus.MemWrite = 1'b1;
            bus.AdrSrc   = 1'b1;
            bus.retire   = bus.mem_ready;
         end
         S_EXEC_R: begin
            bus.ALUSrcA = SRCA_RS1;
            bus.ALUOp   = ALU_FN;
         end
         S_EXEC_I: begin
            bus.ALUSrcA = SRCA_RS1;
            bus.ALUSrcB = SRCB_IMM;
            bus.ALUOp   = ALU_FN;
         end
         S_ALUWB: begin
            bus.RegWrite = 1'b1;
            bus.retire   = 1'b1;
         end
         S_BRANCH: begin
            bus.ALUSrcA = SRCA_RS1;
            bus.ALUOp   = ALU_SUB;
            bus.PCWrite = bus.zero;
            bus.retire  = 1'b1;
         end
         S_JAL: begin
            bus.ALUSrcA = SRCA_OLDPC;
            bus.ALUSrcB = SRCB_4;
            bus.PCWrite = 1'b1;
         end
         S_LUI: begin
            bus.ALUSrcA = SRCA_ZERO;
            bus.ALUSrcB = SRCB_IMM;
         end
         default: ;
      endcase
   end

   assign bus.bus_err = bus_err_q;
   assign bus.illegal = illegal_q;
   assign bus.state   = st;

endmodule
